// File: rtl/key_entry_ctrl.sv
// rtl/key_entry_ctrl.sv - PS/2 key entry: scancode filtering, ASCII block assembly, echo
//
// Purpose:
//   Accepts raw PS/2 set-2 scancodes and drops break (F0 xx) and extended
//   (E0 xx / E0 F0 xx) sequences. It translates the remaining make codes
//   (A-Z, 0-9) to ASCII and stores them in an NBYTES-character block. The
//   block is handed over on a valid/ready handshake, and each accepted
//   character (or backspace) is echoed for display.
//
// Optional feature macro: AUTO_COMMIT_EN
//   When this macro is defined, storing the NBYTES-th character presents the
//   block at once, so no Enter is needed. Enter still commits a partial block.
//
// Parameters:
//   NBYTES      characters per block (>=1)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   scan_valid  in   1-cycle strobe, scan_code holds a new byte
//   scan_code   in   raw scancode byte
//   blk_valid   out  block available
//   blk_ready   in   consumer accepts the block
//   blk_data    out  first char in [8*NBYTES-1 -: 8], unfilled bytes 00
//   chr_valid   out  1-cycle echo strobe
//   chr_data    out  echoed ASCII (08 for backspace)
//   count       out  characters currently buffered

module key_entry_ctrl #(
  parameter int NBYTES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         scan_valid,
  input  logic [7:0]                   scan_code,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  output logic [8*NBYTES-1:0]          blk_data,
  output logic                         chr_valid,
  output logic [7:0]                   chr_data,
  output logic [$clog2(NBYTES+1)-1:0]  count
);

  localparam int CW = $clog2(NBYTES + 1);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] FULL = CW'(NBYTES);
`ifdef AUTO_COMMIT_EN
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
`endif

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] ASC_BS   = 8'h08;

  typedef enum logic [1:0] {COLLECT, BREAK, EXT, PRESENT} state_t;
  // Prefix tracking while a block waits in PRESENT, so that a release or an
  // extended sequence split across the handshake is still swallowed.
  typedef enum logic [1:0] {SH_NONE, SH_BRK, SH_EXT} shadow_t;

  state_t      state, state_nxt;
  shadow_t     shadow, shadow_nxt;
  logic [CW-1:0] cnt_nxt, cnt_dec;
  logic [7:0]  mem [NBYTES];
  logic        wr_en, clr_all, echo;
  logic [IW-1:0] wr_idx;
  logic [7:0]  wr_byte, echo_data, ascii;

  // Set-2 make code to ASCII. 00 marks an unmapped code.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
      8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
      8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
      8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
      8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
      8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  assign ascii   = scan_to_ascii(scan_code);
  assign cnt_dec = count - CW'(1);

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    cnt_nxt    = count;
    wr_en      = 1'b0;
    wr_idx     = count[IW-1:0];
    wr_byte    = 8'h00;
    clr_all    = 1'b0;
    echo       = 1'b0;
    echo_data  = 8'h00;

    case (state)
      COLLECT: begin
        if (scan_valid) begin
          if (scan_code == SC_BREAK) begin
            state_nxt = BREAK;
          end else if (scan_code == SC_EXT) begin
            state_nxt = EXT;
          end else if (scan_code == SC_ENTER) begin
            if (count != '0) state_nxt = PRESENT;
          end else if (scan_code == SC_BKSP) begin
            if (count != '0) begin
              cnt_nxt   = cnt_dec;
              wr_en     = 1'b1;
              wr_idx    = cnt_dec[IW-1:0];
              wr_byte   = 8'h00;
              echo      = 1'b1;
              echo_data = ASC_BS;
            end
          end else if (ascii != 8'h00 && count < FULL) begin
            wr_en     = 1'b1;
            wr_byte   = ascii;
            cnt_nxt   = count + CW'(1);
            echo      = 1'b1;
            echo_data = ascii;
`ifdef AUTO_COMMIT_EN
            if (count == LAST) state_nxt = PRESENT;
`endif
          end
        end
      end

      BREAK: begin
        if (scan_valid) state_nxt = COLLECT;
      end

      EXT: begin
        if (scan_valid) state_nxt = (scan_code == SC_BREAK) ? BREAK : COLLECT;
      end

      PRESENT: begin
        if (scan_valid) begin
          case (shadow)
            SH_NONE: begin
              if (scan_code == SC_BREAK)    shadow_nxt = SH_BRK;
              else if (scan_code == SC_EXT) shadow_nxt = SH_EXT;
            end
            SH_BRK:  shadow_nxt = SH_NONE;
            SH_EXT:  shadow_nxt = (scan_code == SC_BREAK) ? SH_BRK : SH_NONE;
            default: shadow_nxt = SH_NONE;
          endcase
        end
        if (blk_ready) begin
          clr_all = 1'b1;
          cnt_nxt = '0;
          // Resume in whichever prefix state is still open.
          case (shadow_nxt)
            SH_BRK:  state_nxt = BREAK;
            SH_EXT:  state_nxt = EXT;
            default: state_nxt = COLLECT;
          endcase
          shadow_nxt = SH_NONE;
        end
      end

      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      shadow    <= SH_NONE;
      count     <= '0;
      chr_valid <= 1'b0;
      chr_data  <= 8'h00;
      for (int i = 0; i < NBYTES; i++) mem[i] <= 8'h00;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      count     <= cnt_nxt;
      chr_valid <= echo;
      chr_data  <= echo_data;
      if (clr_all) begin
        for (int i = 0; i < NBYTES; i++) mem[i] <= 8'h00;
      end else if (wr_en) begin
        mem[wr_idx] <= wr_byte;
      end
    end
  end

  assign blk_valid = (state == PRESENT);

  always_comb begin
    blk_data = '0;
    for (int i = 0; i < NBYTES; i++) blk_data[8*(NBYTES-1-i) +: 8] = mem[i];
  end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// tb/tb_key_entry_ctrl.sv - scoreboard bench for key_entry_ctrl (NBYTES=4)

module tb_key_entry_ctrl;

  localparam int NB = 4;
  localparam int CW = $clog2(NB + 1);

  logic            clk;
  logic            rst_n;
  logic            scan_valid;
  logic [7:0]      scan_code;
  logic            blk_valid;
  logic            blk_ready;
  logic [8*NB-1:0] blk_data;
  logic            chr_valid;
  logic [7:0]      chr_data;
  logic [CW-1:0]   count;

  int checks   = 0;
  int failures = 0;

  logic [7:0]      exp_chr [$];
  logic [8*NB-1:0] exp_blk [$];

  key_entry_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .scan_valid(scan_valid), .scan_code(scan_code),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .chr_valid(chr_valid), .chr_data(chr_data), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(posedge clk); #1;
    scan_code  = c;
    scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops expected echoes and blocks as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chr_valid) begin
        if (exp_chr.size() == 0) chk("unexpected_echo", {56'h0, chr_data}, 64'hFFFF);
        else chk("echo", {56'h0, chr_data}, {56'h0, exp_chr.pop_front()});
      end
      if (blk_valid && blk_ready) begin
        if (exp_blk.size() == 0) chk("unexpected_block", {32'h0, blk_data}, 64'hFFFF);
        else chk("block", {32'h0, blk_data}, {32'h0, exp_blk.pop_front()});
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    scan_valid = 1'b0;
    scan_code  = 8'h00;
    blk_ready  = 1'b0;
    #12;
    chk("rst_blk_valid", {63'h0, blk_valid}, 64'h0);
    chk("rst_chr_valid", {63'h0, chr_valid}, 64'h0);
    chk("rst_count", {61'h0, count}, 64'h0);
    chk("rst_blk_data", {32'h0, blk_data}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Releases of A and B are swallowed; Enter commits "AB".
    blk_ready = 1'b1;
    exp_chr.push_back(8'h41);
    send(8'h1C);
    chk("t2_count_a", {61'h0, count}, 64'd1);
    send(8'hF0);
    send(8'h1C);
    exp_chr.push_back(8'h42);
    send(8'h32);
    send(8'hF0);
    send(8'h32);
    chk("t2_count_ab", {61'h0, count}, 64'd2);
    exp_blk.push_back(32'h41420000);
    send(8'h5A);
    chk("t2_blk_valid_up", {63'h0, blk_valid}, 64'h1);
    idle(1);
    chk("t2_blk_valid_down", {63'h0, blk_valid}, 64'h0);
    chk("t2_count_clr", {61'h0, count}, 64'h0);

    // Backspace, then a silent backspace on an empty buffer.
    exp_chr.push_back(8'h41);
    send(8'h1C);
    exp_chr.push_back(8'h08);
    send(8'h66);
    send(8'h66);
    chk("t3_count_empty", {61'h0, count}, 64'h0);
    exp_chr.push_back(8'h42);
    send(8'h32);
    exp_blk.push_back(32'h42000000);
    send(8'h5A);
    idle(2);
    chk("t3_count_clr", {61'h0, count}, 64'h0);

    // Extended make and extended release, then Enter on an empty buffer.
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    send(8'h5A);
    idle(3);
    chk("t4_blk_valid", {63'h0, blk_valid}, 64'h0);
    chk("t4_count", {61'h0, count}, 64'h0);

    // Fill "1234", overflow char dropped, block held until ready.
    blk_ready = 1'b0;
    exp_chr.push_back(8'h31); send(8'h16);
    exp_chr.push_back(8'h32); send(8'h1E);
    exp_chr.push_back(8'h33); send(8'h26);
    exp_chr.push_back(8'h34); send(8'h25);
    send(8'h2E);
    chk("t5_count_full", {61'h0, count}, 64'd4);
    send(8'h5A);
    for (int i = 0; i < 10; i++) begin
      chk("t5_blk_hold", {63'h0, blk_valid}, 64'h1);
      chk("t5_blk_data_hold", {32'h0, blk_data}, 64'h31323334);
      idle(1);
    end
    exp_blk.push_back(32'h31323334);
    blk_ready = 1'b1;
    idle(1);
    chk("t5_blk_valid_down", {63'h0, blk_valid}, 64'h0);
    chk("t5_count_clr", {61'h0, count}, 64'h0);

`ifdef AUTO_COMMIT_EN
    // Fourth char commits by itself; make codes during PRESENT are silent.
    blk_ready = 1'b0;
    exp_chr.push_back(8'h31); send(8'h16);
    exp_chr.push_back(8'h32); send(8'h1E);
    exp_chr.push_back(8'h33); send(8'h26);
    exp_chr.push_back(8'h34); send(8'h25);
    chk("t6_echo_with_valid", {62'h0, chr_valid, blk_valid}, 64'h3);
    send(8'h1C);
    chk("t6_no_echo_present", {63'h0, chr_valid}, 64'h0);
    exp_blk.push_back(32'h31323334);
    blk_ready = 1'b1;
    idle(2);
    chk("t6_blk_valid_down", {63'h0, blk_valid}, 64'h0);
`endif

    // Asynchronous reset while a block is presented.
    blk_ready = 1'b0;
    exp_chr.push_back(8'h41);
    send(8'h1C);
    send(8'h5A);
    chk("t1_in_present", {63'h0, blk_valid}, 64'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t1_blk_valid", {63'h0, blk_valid}, 64'h0);
    chk("t1_count", {61'h0, count}, 64'h0);
    chk("t1_chr_valid", {63'h0, chr_valid}, 64'h0);
    chk("t1_blk_data", {32'h0, blk_data}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    chk("t1_after_blk_valid", {63'h0, blk_valid}, 64'h0);

    chk("leftover_echoes", 64'(exp_chr.size()), 64'h0);
    chk("leftover_blocks", 64'(exp_blk.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
